alu_top: RTL and testbench
==========================

ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 8, clock cycles each display digit stays enabled before advancing.
REQ-003 SHALL have port Clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pb_a  input  1  raw, bouncing, asynchronous button; press loads operand A.
REQ-006 SHALL have port pb_b  input  1  raw, bouncing, asynchronous button; press loads operand B.
REQ-007 SHALL have port pb_op  input  1  raw, bouncing, asynchronous button; press loads opcode.
REQ-008 SHALL have port sw  input  8  switch value sampled on a load.
REQ-009 SHALL have port LED  output  8  registered result[7:0].
REQ-010 SHALL have port AN_SEL  output  4  active-low digit enables, one-hot-low.
REQ-011 SHALL have port seven_seg_out  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: counter increments while synchronized level differs from debounced level, clears when equal; at DEBOUNCE_CYCLES the debounced level flips and counter clears.
REQ-013 Each debounced signal SHALL produce a one-cycle press pulse on its 0->1 transition only; release produces nothing; holding produces exactly one pulse.
REQ-014 Bouncing that toggles faster than DEBOUNCE_CYCLES SHALL produce no pulse; a stable high of at least DEBOUNCE_CYCLES+3 cycles SHALL produce exactly one.
REQ-015 pb_a pulse SHALL load A <= sw on the next edge; pb_b pulse SHALL load B <= sw; pb_op pulse SHALL load OP <= sw[2:0] (sw[7:3] ignored).
REQ-016 Simultaneous pulses SHALL each perform their own load in the same cycle, each from the same sw value.
REQ-017 Opcodes (9-bit R, R[8]=carry/borrow flag): 000 R={0,A}; 001 R=A+B; 010 R=A-B (R[8]=1 when A<B); 011 R={0,A&B}; 100 R={0,A|B}; 101 R={0,A^B}; 110 R={0,~A}; 111 R={A[7],A<<1}.
REQ-018 Arithmetic SHALL be unsigned 8-bit, wrapping modulo 256 in R[7:0].
REQ-019 Result register SHALL update every cycle from current A, B, OP: LED reflects any load two edges after its press pulse.
REQ-020 Display SHALL scan digits 0->1->2->3->0, advancing every REFRESH_CYCLES cycles; exactly one AN_SEL bit low.
REQ-021 Digit contents: digit0 = hex R[3:0], digit1 = hex R[7:4], digit2 = hex {0,OP}, digit3 = hex {000,R[8]}.
REQ-022 Hex decode (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 seven_seg_out and AN_SEL SHALL be registered and change together.

Reset
REQ-024 While reset=1 at a rising edge: A, B, OP, R = 0; LED = 8'h00; synchronizers, debounced levels, debounce counters, refresh counter = 0; scan index = digit0.
REQ-025 After reset: AN_SEL = 4'b1110 and seven_seg_out = 7'b1000000.
REQ-026 Reset asserted mid-bounce or mid-hold SHALL discard the pending press; a button still held after reset SHALL produce one pulse once stable for DEBOUNCE_CYCLES.

Verification
REQ-027 Reset 10 cycles -> LED=00, AN_SEL=1110, seven_seg_out=1000000; scan visits 1101, 1011, 0111 at REFRESH_CYCLES intervals.
REQ-028 sw=0x0F, pb_a toggling every cycle for 30 cycles then high 27 cycles -> exactly one load, A=0x0F, LED=0x0F (OP=000).
REQ-029 Then sw=0x05 with same pb_b pattern, then sw=0x01 with same pb_op pattern -> LED=0x14; digits 0..3 show 4,1,1,0.
REQ-030 A=0x05, B=0x0F, OP=010 -> LED=0xF6, digit3 shows 1; A=0xFF, B=0x01, OP=001 -> LED=0x00, digit3 shows 1.
REQ-031 pb_a and pb_b pressed identically with sw=0x3C -> A=B=0x3C; OP=101 -> LED=0x00.
REQ-032 Reset raised during a clean pb_a hold after 10 stable cycles -> no A load until a further DEBOUNCE_CYCLES stable cycles after reset release.

Source files
------------

// File: rtl/alu_top.sv
`default_nettype none
// ============================================================================
// Module   : alu_top
// Purpose  : Push-button driven 8-bit ALU with a scanned 4-digit 7-segment
//            display. Three raw buttons are synchronized and debounced. A press
//            loads operand A, operand B or the opcode from the switches. The
//            registered 9-bit result drives the LEDs and the display.
// Ports    : Clk           - system clock, rising edge
//            reset         - synchronous active-high reset
//            pb_a/pb_b     - raw buttons loading operand A / operand B from sw
//            pb_op         - raw button loading opcode from sw[2:0]
//            sw[7:0]       - switch value sampled on a load
//            LED[7:0]      - result[7:0]
//            AN_SEL[3:0]   - active-low digit enables (one-hot-low)
//            seven_seg_out - active-low segments {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module alu_top #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REFRESH_CYCLES  = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       pb_a,
    input  logic       pb_b,
    input  logic       pb_op,
    input  logic [7:0] sw,
    output logic [7:0] LED,
    output logic [3:0] AN_SEL,
    output logic [6:0] seven_seg_out
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RF_W = $clog2(REFRESH_CYCLES + 1);

    // ------------------------------------------------------------------
    // Button conditioning: sync -> debounce -> rising-edge press pulse
    // ------------------------------------------------------------------
    logic [2:0] raw_btn;
    logic [2:0] press;   // bit0 = A, bit1 = B, bit2 = OP

    assign raw_btn = {pb_op, pb_b, pb_a};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic            sync1;
        logic            sync2;
        logic            deb;
        logic            deb_q;
        logic [DB_W-1:0] db_cnt;

        always_ff @(posedge Clk) begin
            if (reset) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                deb    <= 1'b0;
                deb_q  <= 1'b0;
                db_cnt <= '0;
            end else begin
                sync1 <= raw_btn[i];
                sync2 <= sync1;
                deb_q <= deb;
                if (sync2 != deb) begin
                    // Flip on the DEBOUNCE_CYCLES-th consecutive differing sample.
                    if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb    <= sync2;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end else begin
                    db_cnt <= '0;
                end
            end
        end

        // One pulse per accepted 0->1 transition; releases are ignored.
        assign press[i] = deb & ~deb_q;
    end

    // ------------------------------------------------------------------
    // Operand / opcode registers and ALU
    // ------------------------------------------------------------------
    logic [7:0] opnd_a;
    logic [7:0] opnd_b;
    logic [2:0] opcode;
    logic [8:0] result;
    logic [8:0] alu_next;

    always_ff @(posedge Clk) begin
        if (reset) begin
            opnd_a <= 8'h00;
            opnd_b <= 8'h00;
            opcode <= 3'b000;
        end else begin
            // Independent loads so simultaneous presses all take effect.
            if (press[0]) opnd_a <= sw;
            if (press[1]) opnd_b <= sw;
            if (press[2]) opcode <= sw[2:0];
        end
    end

    always_comb begin
        alu_next = 9'h000;
        case (opcode)
            3'b000:  alu_next = {1'b0, opnd_a};
            3'b001:  alu_next = {1'b0, opnd_a} + {1'b0, opnd_b};
            // 9-bit difference: bit 8 becomes the borrow when A < B.
            3'b010:  alu_next = {1'b0, opnd_a} - {1'b0, opnd_b};
            3'b011:  alu_next = {1'b0, opnd_a & opnd_b};
            3'b100:  alu_next = {1'b0, opnd_a | opnd_b};
            3'b101:  alu_next = {1'b0, opnd_a ^ opnd_b};
            3'b110:  alu_next = {1'b0, ~opnd_a};
            default: alu_next = {opnd_a[7], opnd_a[6:0], 1'b0};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            result <= 9'h000;
        end else begin
            result <= alu_next;
        end
    end

    assign LED = result[7:0];

    // ------------------------------------------------------------------
    // Display scan state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    digit_t          digit;
    digit_t          digit_next;
    logic [RF_W-1:0] refresh_cnt;

    always_ff @(posedge Clk) begin
        if (reset) begin
            digit       <= DIG0;
            refresh_cnt <= '0;
        end else if (refresh_cnt == RF_W'(REFRESH_CYCLES - 1)) begin
            digit       <= digit_next;
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        digit_next = digit;
        case (digit)
            DIG0:    digit_next = DIG1;
            DIG1:    digit_next = DIG2;
            DIG2:    digit_next = DIG3;
            default: digit_next = DIG0;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit content, hex decode and registered display outputs
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [3:0] nibble;
    logic [3:0] an_next;

    always_comb begin
        nibble  = 4'h0;
        an_next = 4'b1110;
        case (digit)
            DIG0: begin
                nibble  = result[3:0];
                an_next = 4'b1110;
            end
            DIG1: begin
                nibble  = result[7:4];
                an_next = 4'b1101;
            end
            DIG2: begin
                nibble  = {1'b0, opcode};
                an_next = 4'b1011;
            end
            default: begin
                nibble  = {3'b000, result[8]};
                an_next = 4'b0111;
            end
        endcase
    end

    // Enables and segments share one register stage so they switch together.
    always_ff @(posedge Clk) begin
        if (reset) begin
            AN_SEL        <= 4'b1110;
            seven_seg_out <= 7'b1000000;
        end else begin
            AN_SEL        <= an_next;
            seven_seg_out <= hex7(nibble);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_top
// Purpose  : Self-checking bench for alu_top. Expected values come from a
//            bench-side model of the operand registers and ALU and are queued
//            when stimulus is applied, then popped when the DUT output is read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_top;

    localparam int DB = 16;
    localparam int RF = 8;

    logic       Clk   = 1'b0;
    logic       reset = 1'b1;
    logic       pb_a  = 1'b0;
    logic       pb_b  = 1'b0;
    logic       pb_op = 1'b0;
    logic [7:0] sw    = 8'h00;
    logic [7:0] LED;
    logic [3:0] AN_SEL;
    logic [6:0] seven_seg_out;

    always #5 Clk = ~Clk;

    alu_top #(
        .DEBOUNCE_CYCLES(DB),
        .REFRESH_CYCLES (RF)
    ) dut (
        .Clk          (Clk),
        .reset        (reset),
        .pb_a         (pb_a),
        .pb_b         (pb_b),
        .pb_op        (pb_op),
        .sw           (sw),
        .LED          (LED),
        .AN_SEL       (AN_SEL),
        .seven_seg_out(seven_seg_out)
    );

    typedef struct {
        string tag;
        int    exp;
    } sb_t;

    sb_t        sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_a     = 8'h00;
    logic [7:0] m_b     = 8'h00;
    logic [2:0] m_op    = 3'b000;
    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input string tag, input int got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, got, -1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        logic [8:0] r;
        case (op)
            3'd0:    r = {1'b0, a};
            3'd1:    r = 9'(a) + 9'(b);
            3'd2:    r = 9'(a) - 9'(b);
            3'd3:    r = {1'b0, a & b};
            3'd4:    r = {1'b0, a | b};
            3'd5:    r = {1'b0, a ^ b};
            3'd6:    r = {1'b0, ~a};
            default: r = {a, 1'b0};
        endcase
        return r;
    endfunction

    task automatic drive(input logic [2:0] mask, input logic v);
        if (mask[0]) pb_a  = v;
        if (mask[1]) pb_b  = v;
        if (mask[2]) pb_op = v;
    endtask

    // Bounce 30 cycles, hold 27 cycles, release 30 cycles; counts press pulses.
    task automatic do_press(input string tag, input logic [2:0] mask, input logic [7:0] val);
        int   pulses;
        logic v;
        logic [8:0] r;
        if (mask[0]) m_a  = val;
        if (mask[1]) m_b  = val;
        if (mask[2]) m_op = val[2:0];
        r = alu_model(m_a, m_b, m_op);
        sb_push({tag, "_led"}, int'(r[7:0]));
        pulses = 0;
        sw     = val;
        for (int i = 0; i < 87; i++) begin
            @(negedge Clk);
            pulses += $countones(dut.press & mask);
            if (i < 30) v = (i % 2 == 0);
            else        v = (i < 57);
            drive(mask, v);
        end
        check({tag, "_pulses"}, pulses, $countones(mask));
        sb_pop({tag, "_led"}, int'(LED));
    endtask

    task automatic wait_an(input logic [3:0] target, output int cyc);
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (AN_SEL != target && cyc < 5 * RF);
    endtask

    task automatic check_digit(input string tag, input int d, input logic [3:0] nib);
        int         cyc;
        logic [3:0] an_exp;
        an_exp = ~(4'b0001 << d);
        sb_push(tag, int'(seg_tbl[nib]));
        wait_an(an_exp, cyc);
        check({tag, "_an"}, int'(AN_SEL), int'(an_exp));
        sb_pop(tag, int'(seven_seg_out));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         pulses;
        logic [3:0] scan_exp [3];
        logic [8:0] r;

        // Reset and initial display state
        reset = 1'b1;
        repeat (10) @(negedge Clk);
        sb_push("rst_led", 8'h00);
        sb_push("rst_an", 4'b1110);
        sb_push("rst_seg", 7'b1000000);
        sb_pop("rst_led", int'(LED));
        sb_pop("rst_an", int'(AN_SEL));
        sb_pop("rst_seg", int'(seven_seg_out));
        reset = 1'b0;

        // Scan order and interval
        wait_an(4'b1101, cyc);
        check("scan_first", int'(AN_SEL), 4'b1101);
        scan_exp[0] = 4'b1011;
        scan_exp[1] = 4'b0111;
        scan_exp[2] = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            sb_push($sformatf("scan_an%0d", k), int'(scan_exp[k]));
            wait_an(scan_exp[k], cyc);
            sb_pop("scan_an", int'(AN_SEL));
            check($sformatf("scan_interval%0d", k), cyc, RF);
            check($sformatf("scan_onehot%0d", k), $countones(~AN_SEL), 1);
        end

        // Bounced loads; OP=000 passes A, then OP=001 adds
        do_press("load_a", 3'b001, 8'h0F);
        do_press("load_b", 3'b010, 8'h05);
        do_press("load_op", 3'b100, 8'h01);
        check("add_led", int'(LED), 8'h14);
        check_digit("add_dig0", 0, 4'h4);
        check_digit("add_dig1", 1, 4'h1);
        check_digit("add_dig2", 2, 4'h1);
        check_digit("add_dig3", 3, 4'h0);

        // Subtract with borrow
        do_press("sub_a", 3'b001, 8'h05);
        do_press("sub_b", 3'b010, 8'h0F);
        do_press("sub_op", 3'b100, 8'h02);
        check("sub_led", int'(LED), 8'hF6);
        check_digit("sub_borrow", 3, 4'h1);

        // Add with carry-out and wrap
        do_press("carry_a", 3'b001, 8'hFF);
        do_press("carry_b", 3'b010, 8'h01);
        do_press("carry_op", 3'b100, 8'h01);
        check("carry_led", int'(LED), 8'h00);
        check_digit("carry_flag", 3, 4'h1);

        // Simultaneous A/B load, then XOR, NOT and shift
        do_press("dual_ab", 3'b011, 8'h3C);
        do_press("xor_op", 3'b100, 8'h05);
        check("xor_led", int'(LED), 8'h00);
        do_press("not_op", 3'b100, 8'hFE);
        check("not_led", int'(LED), 8'hC3);
        do_press("shl_op", 3'b100, 8'h07);
        check("shl_led", int'(LED), 8'h78);
        check_digit("shl_dig2", 2, 4'h7);

        // Reset during a clean hold discards the pending press
        sw     = 8'h77;
        pulses = 0;
        pb_a   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            pulses += int'(dut.press[0]);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            pulses += int'(dut.press[0]);
        end
        check("hold_rst_pulses", pulses, 0);
        reset = 1'b0;
        m_a   = 8'h00;
        m_b   = 8'h00;
        m_op  = 3'b000;
        for (int i = 0; i < DB; i++) begin
            @(negedge Clk);
            pulses += int'(dut.press[0]);
        end
        check("hold_early_led", int'(LED), 8'h00);
        m_a = 8'h77;
        r   = alu_model(m_a, m_b, m_op);
        sb_push("hold_late_led", int'(r[7:0]));
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            pulses += int'(dut.press[0]);
        end
        check("hold_pulses", pulses, 1);
        sb_pop("hold_late_led", int'(LED));
        pb_a = 1'b0;
        repeat (30) @(negedge Clk);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
